crop_scheduler: RTL

Arbitrating controller for the random-resized-crop augmentation. It serves two view requesters (view A and view B of the self-supervised pair) with round-robin arbitration and steps an internal 10-bit LFSR to draw a crop scale and X/Y offsets. It returns a clamped crop window (size, x, y) over a valid/ready output to the crop datapath. It sits between the augmentation sequencer and the image-resize datapath.

---
 rtl/crop_pkg.sv | 17 +
 rtl/crop_lfsr.sv | 19 +
 rtl/crop_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/crop_pkg.sv
// Shared types and defaults for the random-resized-crop scheduler.
package crop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCALE,
    XOFF,
    YOFF,
    OUT
  } state_t;

  localparam int unsigned IMG_SIZE_DEF = 28;
  localparam int unsigned COORD_W_DEF  = 5;
  localparam logic [9:0]  SEED_DEF     = 10'b0000101001;
  localparam int unsigned SCALE_STEP   = 4;

endpackage

// File: rtl/crop_lfsr.sv
// 10-bit XNOR LFSR; steps once per cycle while en is high.
module crop_lfsr #(
  parameter logic [9:0] SEED = crop_pkg::SEED_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] state
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[3] ~^ state[0], state[9:1]};
    end
  end

endmodule

// File: rtl/crop_scheduler.sv
// Round-robin crop scheduler for two views: draws scale and offsets from an LFSR.
module crop_scheduler
  import crop_pkg::*;
#(
  parameter int unsigned IMG_SIZE = IMG_SIZE_DEF,
  parameter int unsigned COORD_W  = COORD_W_DEF,
  parameter logic [9:0]  SEED     = SEED_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic               bypass,
  output logic [1:0]         ack,
  output logic               crop_valid,
  input  logic               crop_ready,
  output logic               crop_id,
  output logic [COORD_W-1:0] crop_size,
  output logic [COORD_W-1:0] crop_x,
  output logic [COORD_W-1:0] crop_y,
  output logic               busy
);

  state_t             state;
  logic [9:0]         lfsr;
  logic               lfsr_en;
  logic               last_grant;
  logic [COORD_W-1:0] max_off;
  logic [COORD_W-1:0] step_off;
  logic [COORD_W-1:0] draw;
  logic [COORD_W-1:0] clamped;
  logic [1:0]         pending;
  logic               accept;
  logic               grant_valid;
  logic               grant_id;

  crop_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .state (lfsr)
  );

  always_comb begin
    accept  = (state == OUT) && crop_valid && crop_ready;
    lfsr_en = (state == SCALE) || (state == XOFF) || (state == YOFF);
    // The view being accepted still holds req until its ack; it must not win again.
    pending = req;
    if (state == OUT) pending[crop_id] = 1'b0;
    grant_valid = (|pending) && ((state == IDLE) || accept);
    if (pending == 2'b11) grant_id = ~last_grant;
    else                  grant_id = pending[1];
    step_off = COORD_W'(SCALE_STEP) * COORD_W'(lfsr[1:0]);
    draw     = COORD_W'(lfsr & 10'h01F);
    clamped  = (draw > max_off) ? max_off : draw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ack        <= '0;
      crop_valid <= 1'b0;
      busy       <= 1'b0;
      crop_id    <= 1'b0;
      crop_size  <= COORD_W'(IMG_SIZE);
      crop_x     <= '0;
      crop_y     <= '0;
      last_grant <= 1'b1;
      max_off    <= '0;
    end else begin
      ack <= '0;
      if (accept) ack[crop_id] <= 1'b1;
      case (state)
        IDLE, OUT: begin
          if (grant_valid) begin
            crop_id    <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            if (bypass) begin
              state      <= OUT;
              crop_valid <= 1'b1;
              crop_size  <= COORD_W'(IMG_SIZE);
              crop_x     <= '0;
              crop_y     <= '0;
            end else begin
              state      <= SCALE;
              crop_valid <= 1'b0;
            end
          end else if (accept) begin
            state      <= IDLE;
            crop_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        SCALE: begin
          max_off   <= step_off;
          crop_size <= COORD_W'(IMG_SIZE) - step_off;
          state     <= XOFF;
        end
        XOFF: begin
          crop_x <= clamped;
          state  <= YOFF;
        end
        YOFF: begin
          crop_y     <= clamped;
          crop_valid <= 1'b1;
          state      <= OUT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
